// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and owner encoding for the FIR memory arbiter
package fir_pkg;

  localparam int FIR_ADDR_W   = 10;
  localparam int FIR_DATA_W   = 16;
  localparam int FIR_MAX_WAIT = 8;

  typedef enum logic [1:0] {
    OWN_IDLE   = 2'd0,
    OWN_HOST   = 2'd1,
    OWN_ENGINE = 2'd2
  } owner_e;

  function automatic owner_e owner_of(input logic host_gnt, input logic fsm_gnt);
    if (host_gnt) return OWN_HOST;
    if (fsm_gnt)  return OWN_ENGINE;
    return OWN_IDLE;
  endfunction

endpackage

// File: rtl/fir_arb_starve.sv
// rtl/fir_arb_starve.sv - host starvation counter, saturating at MAX_WAIT
module fir_arb_starve #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_req,
  input  logic             host_gnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!host_req || host_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_cnt = wait_cnt_q;
  assign at_limit = (wait_cnt_q == LIMIT);

endmodule

// File: rtl/fir_mem_arbiter.sv
// rtl/fir_mem_arbiter.sv - single-port RAM arbiter between host and FIR engine
module fir_mem_arbiter
  import fir_pkg::*;
#(
  parameter int ADDR_W   = FIR_ADDR_W,
  parameter int DATA_W   = FIR_DATA_W,
  parameter int MAX_WAIT = FIR_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pracuje,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  input  logic              fsm_req,
  input  logic              fsm_we,
  input  logic [ADDR_W-1:0] fsm_addr,
  input  logic [DATA_W-1:0] fsm_wdata,
  output logic              fsm_gnt,
  output logic              fsm_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic             at_limit;
  logic [CNT_W-1:0] wait_cnt;
  logic             host_win;

  logic   host_rvalid_q, host_rvalid_d;
  logic   fsm_rvalid_q,  fsm_rvalid_d;
  owner_e dbg_state_q,   dbg_state_d;

  fir_arb_starve #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .host_req (host_req),
    .host_gnt (host_gnt),
    .wait_cnt (wait_cnt),
    .at_limit (at_limit)
  );

  // Engine wins contention only while busy, and only until the host has starved MAX_WAIT cycles.
  always_comb begin
    host_win  = host_req & (~fsm_req | ~pracuje | at_limit);
    host_gnt  = rst_n & host_win;
    fsm_gnt   = rst_n & fsm_req & ~host_win;
    mem_en    = host_gnt | fsm_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (fsm_gnt) begin
      mem_we    = fsm_we;
      mem_addr  = fsm_addr;
      mem_wdata = fsm_wdata;
    end
    host_rvalid_d = host_gnt & ~host_we;
    fsm_rvalid_d  = fsm_gnt & ~fsm_we;
    dbg_state_d   = owner_of(host_gnt, fsm_gnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rvalid_q <= 1'b0;
      fsm_rvalid_q  <= 1'b0;
      dbg_state_q   <= OWN_IDLE;
    end else begin
      host_rvalid_q <= host_rvalid_d;
      fsm_rvalid_q  <= fsm_rvalid_d;
      dbg_state_q   <= dbg_state_d;
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign fsm_rvalid  = fsm_rvalid_q;
  assign rdata       = mem_rdata;
  assign dbg_state   = dbg_state_q;

endmodule
